// File: rtl/sha2_arb_pkg.sv
// Shared types and constants for the sha2 engine arbiter.
// Optional wipe feature is enabled with the SHA2_ARB_WIPE_EN macro.
package sha2_arb_pkg;

  localparam int unsigned DataW   = 36;
  localparam int unsigned DigestW = 256;
  localparam int unsigned LfsrW   = 32;

  localparam logic [LfsrW-1:0] LfsrSeed = 32'hACE1_2468;
  localparam logic [LfsrW-1:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StStream = 3'd2,
    StWait   = 3'd3,
    StDone   = 3'd4,
    StAbort  = 3'd5,
    StWipe   = 3'd6
  } state_e;

  // One step of the right-shifting Galois LFSR; a nonzero state never reaches zero.
  function automatic logic [LfsrW-1:0] lfsr_step(input logic [LfsrW-1:0] v);
    return (v >> 1) ^ (v[0] ? LfsrTaps : {LfsrW{1'b0}});
  endfunction

endpackage

// File: rtl/sha2_arb_rr_arb_fixed.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arb_fixed #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [PtrW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic [PtrW-1:0]   idx,
  output logic              valid
);

  logic [PtrW-1:0] cand;

  // Cyclic search starting one past the last winner.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = PtrW'((32'(ptr) + i) % NumReq);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha2_arb.sv
// Round-robin sharing of one sha2 engine among NumReq message producers.
// Define SHA2_ARB_WIPE_EN to add a post-message wipe cycle with LFSR data.
module sha2_arb
  import sha2_arb_pkg::*;
#(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned MsgLenW = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq*MsgLenW-1:0] req_len_i,
  input  logic [NumReq-1:0]         req_process_i,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*DataW-1:0]   req_data_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic [NumReq-1:0]         gnt_o,
  output logic [NumReq-1:0]         done_o,
  output logic [DigestW-1:0]        digest_o,
  output logic                      sha_en_o,
  output logic                      hash_start_o,
  output logic                      hash_process_o,
  output logic [MsgLenW-1:0]        message_length_o,
  output logic                      fifo_rvalid_o,
  output logic [DataW-1:0]          fifo_rdata_o,
  input  logic                      fifo_rready_i,
  input  logic                      hash_done_i,
  input  logic [DigestW-1:0]        digest_i
`ifdef SHA2_ARB_WIPE_EN
  ,
  output logic                      wipe_secret_o,
  output logic [LfsrW-1:0]          wipe_v_o
`endif
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

`ifdef SHA2_ARB_WIPE_EN
  localparam state_e StPost = StWipe;
`else
  localparam state_e StPost = StIdle;
`endif

  state_e state_q, state_d;

  logic [NumReq-1:0]  gnt_q, gnt_d, done_q, done_d, arb_gnt;
  logic [PtrW-1:0]    ptr_q, ptr_d, idx_q, idx_d, arb_idx;
  logic [MsgLenW-1:0] len_q, len_d;
  logic [DigestW-1:0] digest_q, digest_d;
  logic               sha_en_q, sha_en_d, start_q, start_d;
  logic               arb_valid, own_req, own_process, mux_on;

  rr_arb_fixed #(.NumReq(NumReq), .PtrW(PtrW)) u_rr_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign own_req     = req_i[idx_q];
  assign own_process = req_process_i[idx_q];
  assign mux_on      = (state_q == StStream) || (state_q == StWait);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next state; a dropped request wins over process/done in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (arb_valid) state_d = StStart;
      StStart:  state_d = own_req ? StStream : StAbort;
      StStream: begin
        if (!own_req)         state_d = StAbort;
        else if (own_process) state_d = StWait;
      end
      StWait: begin
        if (!own_req)         state_d = StAbort;
        else if (hash_done_i) state_d = StDone;
      end
      StDone:   state_d = StPost;
      StAbort:  state_d = StPost;
      StWipe:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode: next values for registered outputs plus the combinational word mux.
  always_comb begin
    gnt_d          = gnt_q;
    idx_d          = idx_q;
    ptr_d          = ptr_q;
    len_d          = len_q;
    digest_d       = digest_q;
    done_d         = '0;
    fifo_rvalid_o  = 1'b0;
    fifo_rdata_o   = '0;
    req_ready_o    = '0;
    hash_process_o = 1'b0;

    if ((state_q == StIdle) && (state_d == StStart)) begin
      gnt_d = arb_gnt;
      idx_d = arb_idx;
      ptr_d = arb_idx;
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (arb_idx == PtrW'(k)) len_d = req_len_i[k*MsgLenW +: MsgLenW];
      end
    end
    if ((state_d == StIdle) || (state_d == StWipe)) gnt_d = '0;

    if ((state_q == StWait) && (state_d == StDone)) begin
      done_d   = gnt_q;
      digest_d = digest_i;
    end

    sha_en_d = (state_d == StStart) || (state_d == StStream) ||
               (state_d == StWait)  || (state_d == StDone);
    start_d  = (state_d == StStart);

    if (mux_on) begin
      fifo_rvalid_o = req_valid_i[idx_q];
      req_ready_o[idx_q] = fifo_rready_i;
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (idx_q == PtrW'(k)) fifo_rdata_o = req_data_i[k*DataW +: DataW];
      end
    end
    hash_process_o = (state_q == StStream) && own_req && own_process;
  end

  // Output and bookkeeping registers; pointer resets so requester 0 goes first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= PtrW'(NumReq - 1);
      len_q    <= '0;
      digest_q <= '0;
      done_q   <= '0;
      sha_en_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      digest_q <= digest_d;
      done_q   <= done_d;
      sha_en_q <= sha_en_d;
      start_q  <= start_d;
    end
  end

  assign gnt_o            = gnt_q;
  assign done_o           = done_q;
  assign digest_o         = digest_q;
  assign sha_en_o         = sha_en_q;
  assign hash_start_o     = start_q;
  assign message_length_o = len_q;

`ifdef SHA2_ARB_WIPE_EN
  logic [LfsrW-1:0] lfsr_q, wipe_v_q;
  logic             wipe_q;

  // Free-running LFSR sampled into the wipe value on entry to Wipe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q   <= LfsrSeed;
      wipe_q   <= 1'b0;
      wipe_v_q <= '0;
    end else begin
      lfsr_q   <= lfsr_step(lfsr_q);
      wipe_q   <= (state_d == StWipe);
      wipe_v_q <= (state_d == StWipe) ? lfsr_q : '0;
    end
  end

  assign wipe_secret_o = wipe_q;
  assign wipe_v_o      = wipe_v_q;
`endif

endmodule

// File: tb/tb_sha2_arb.sv
// Directed self-checking bench for sha2_arb; the engine side is driven by hand.
module tb_sha2_arb;

  localparam logic [255:0] DAbc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DMux = {8{32'h1234_abcd}};
  localparam logic [255:0] DAb2 = {8{32'h5a5a_0f0f}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req, process, valid, ready, gnt, done;
  logic [127:0] len;
  logic [71:0]  data;
  logic [255:0] digest, digest_in;
  logic         sha_en, hash_start, hash_process, rvalid, rready, hash_done;
  logic [63:0]  msg_len;
  logic [35:0]  rdata;
`ifdef SHA2_ARB_WIPE_EN
  logic         wipe_secret;
  logic [31:0]  wipe_v;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sha2_arb #(.NumReq(2), .MsgLenW(64)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_i            (req),
    .req_len_i        (len),
    .req_process_i    (process),
    .req_valid_i      (valid),
    .req_data_i       (data),
    .req_ready_o      (ready),
    .gnt_o            (gnt),
    .done_o           (done),
    .digest_o         (digest),
    .sha_en_o         (sha_en),
    .hash_start_o     (hash_start),
    .hash_process_o   (hash_process),
    .message_length_o (msg_len),
    .fifo_rvalid_o    (rvalid),
    .fifo_rdata_o     (rdata),
    .fifo_rready_i    (rready),
    .hash_done_i      (hash_done),
    .digest_i         (digest_in)
`ifdef SHA2_ARB_WIPE_EN
    ,
    .wipe_secret_o    (wipe_secret),
    .wipe_v_o         (wipe_v)
`endif
  );

  always #5 clk = ~clk;

  task automatic to_drv();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Extra cycle spent in Wipe after Done/Abort when the feature is built in.
  task automatic wipe_cycle();
`ifdef SHA2_ARB_WIPE_EN
    to_drv();
    to_neg();
    n_checks++;
    if (wipe_secret !== 1'b1 || wipe_v == 32'h0) begin
      n_fail++;
      $display("FAIL wipe_pulse: got secret=%b v=%h want secret=1 v!=0", wipe_secret, wipe_v);
    end
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL wipe_gnt: got %b want 00", gnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; process = '0; valid = '0; len = '0; data = '0;
    rready = 1'b0; hash_done = 1'b0; digest_in = '0;
    to_neg(); to_neg();
    n_checks++;
    if ({gnt, done, sha_en, hash_start, hash_process, rvalid, ready} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b en=%b st=%b pr=%b rv=%b rdy=%b want all 0",
               gnt, done, sha_en, hash_start, hash_process, rvalid, ready);
    end
    n_checks++;
    if (digest !== 256'h0 || msg_len !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got digest=%h len=%h want 0", digest, msg_len);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp;
    logic [255:0] dg;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      dg  = {8{32'(k + 1)}};
      to_drv(); to_neg();
      n_checks++;
      if (gnt !== exp || hash_start !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_gnt%0d: got gnt=%b start=%b want gnt=%b start=1", k, gnt, hash_start, exp);
      end
      to_drv(); process = exp; to_neg();
      n_checks++;
      if (hash_process !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_process%0d: got %b want 1", k, hash_process);
      end
      to_drv(); process = '0; hash_done = 1'b1; digest_in = dg;
      to_drv(); hash_done = 1'b0; to_neg();
      n_checks++;
      if (done !== exp || digest !== dg) begin
        n_fail++;
        $display("FAIL rr_done%0d: got done=%b digest=%h want done=%b digest=%h", k, done, digest, exp, dg);
      end
      wipe_cycle();
      to_drv(); to_neg();
      n_checks++;
      if (gnt !== 2'b00 || done !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_gap%0d: got gnt=%b done=%b want 00 00", k, gnt, done);
      end
    end
    req = '0;
  endtask

  task automatic test_abc();
    req = 2'b01; len[63:0] = 64'd24;
    to_drv(); valid = 2'b01; data[35:0] = 36'hE_6162_6300; to_neg();
    n_checks++;
    if (gnt !== 2'b01 || hash_start !== 1'b1 || sha_en !== 1'b1 || msg_len !== 64'd24 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_start: got gnt=%b st=%b en=%b len=%0d rv=%b want 01 1 1 24 0",
               gnt, hash_start, sha_en, msg_len, rvalid);
    end
    to_drv(); rready = 1'b1; to_neg();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 36'hE_6162_6300 || ready !== 2'b01 || hash_start !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_stream: got rv=%b rdata=%h rdy=%b st=%b want 1 e61626300 01 0",
               rvalid, rdata, ready, hash_start);
    end
    to_drv(); valid = '0; rready = 1'b0; process = 2'b01; to_neg();
    n_checks++;
    if (hash_process !== 1'b1) begin
      n_fail++;
      $display("FAIL abc_process: got %b want 1", hash_process);
    end
    to_drv(); process = '0; hash_done = 1'b1; digest_in = DAbc;
    to_drv(); hash_done = 1'b0; digest_in = '0; to_neg();
    n_checks++;
    if (done !== 2'b01 || digest !== DAbc) begin
      n_fail++;
      $display("FAIL abc_done: got done=%b digest=%h want 01 %h", done, digest, DAbc);
    end
    req = '0;
    wipe_cycle();
    to_drv(); to_neg();
    n_checks++;
    if (done !== 2'b00 || gnt !== 2'b00 || sha_en !== 1'b0 || digest !== DAbc) begin
      n_fail++;
      $display("FAIL abc_idle: got done=%b gnt=%b en=%b digest=%h want 00 00 0 %h",
               done, gnt, sha_en, digest, DAbc);
    end
  endtask

  task automatic test_mux();
    req = 2'b10; len[127:64] = 64'd100;
    to_drv(); len[127:64] = 64'd200; to_neg();
    n_checks++;
    if (gnt !== 2'b10 || msg_len !== 64'd100) begin
      n_fail++;
      $display("FAIL mux_grant: got gnt=%b len=%0d want 10 100", gnt, msg_len);
    end
    to_drv(); valid = 2'b11; data = {36'hF_1234_5678, 36'h0_AAAA_AAAA}; rready = 1'b1; process = 2'b01;
    to_neg();
    n_checks++;
    if (ready !== 2'b10 || rdata !== 36'hF_1234_5678 || rvalid !== 1'b1 || hash_process !== 1'b0) begin
      n_fail++;
      $display("FAIL mux_sel: got rdy=%b rdata=%h rv=%b pr=%b want 10 f12345678 1 0",
               ready, rdata, rvalid, hash_process);
    end
    to_drv(); process = '0; valid = 2'b01; to_neg();
    n_checks++;
    if (rvalid !== 1'b0 || ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mux_other_valid: got rv=%b rdy0=%b want 0 0", rvalid, ready[0]);
    end
    to_drv(); process = 2'b10; to_neg();
    n_checks++;
    if (hash_process !== 1'b1) begin
      n_fail++;
      $display("FAIL mux_process: got %b want 1", hash_process);
    end
    to_drv(); process = '0; valid = 2'b11; hash_done = 1'b1; digest_in = DMux; to_neg();
    n_checks++;
    if (rvalid !== 1'b1 || ready !== 2'b10 || msg_len !== 64'd100) begin
      n_fail++;
      $display("FAIL mux_wait: got rv=%b rdy=%b len=%0d want 1 10 100", rvalid, ready, msg_len);
    end
    to_drv(); hash_done = 1'b0; valid = '0; rready = 1'b0; to_neg();
    n_checks++;
    if (done !== 2'b10 || digest !== DMux) begin
      n_fail++;
      $display("FAIL mux_done: got done=%b digest=%h want 10 %h", done, digest, DMux);
    end
    req = '0;
    wipe_cycle();
    to_drv(); to_neg();
  endtask

  task automatic test_abort();
    req = 2'b11;
    to_drv(); to_neg();
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_gnt0: got %b want 01", gnt);
    end
    to_drv();
    to_drv(); req = 2'b10; process = 2'b01; to_neg();
    n_checks++;
    if (hash_process !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_prio: got process=%b want 0", hash_process);
    end
    to_drv(); process = '0; hash_done = 1'b1; to_neg();
    n_checks++;
    if (sha_en !== 1'b0 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_cycle: got en=%b done=%b want 0 00", sha_en, done);
    end
    hash_done = 1'b0;
    wipe_cycle();
    to_drv(); to_neg();
    n_checks++;
    if (done !== 2'b00 || gnt !== 2'b00 || digest !== DMux) begin
      n_fail++;
      $display("FAIL abort_idle: got done=%b gnt=%b digest=%h want 00 00 %h", done, gnt, digest, DMux);
    end
    to_drv(); to_neg();
    n_checks++;
    if (gnt !== 2'b10 || hash_start !== 1'b1 || sha_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_next: got gnt=%b st=%b en=%b want 10 1 1", gnt, hash_start, sha_en);
    end
    to_drv(); process = 2'b10;
    to_drv(); process = '0; hash_done = 1'b1; digest_in = DAb2;
    to_drv(); hash_done = 1'b0; to_neg();
    n_checks++;
    if (done !== 2'b10 || digest !== DAb2) begin
      n_fail++;
      $display("FAIL abort_done1: got done=%b digest=%h want 10 %h", done, digest, DAb2);
    end
    req = '0;
    wipe_cycle();
    to_drv(); to_neg();
  endtask

  task automatic test_reset_wait();
    req = 2'b01;
    to_drv();
    to_drv(); process = 2'b01;
    to_drv(); process = '0; valid = 2'b01; rready = 1'b1; to_neg();
    n_checks++;
    if (sha_en !== 1'b1 || ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rstw_wait: got en=%b rdy=%b want 1 01", sha_en, ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, done, sha_en, hash_start, hash_process, rvalid, ready} !== 9'b0 ||
        digest !== 256'h0 || msg_len !== 64'h0) begin
      n_fail++;
      $display("FAIL rstw_async: got gnt=%b en=%b rv=%b rdy=%b digest=%h len=%h want all 0",
               gnt, sha_en, rvalid, ready, digest, msg_len);
    end
    to_neg();
    rst_n = 1'b1; req = 2'b11; valid = '0; rready = 1'b0;
    to_drv(); to_neg();
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL rstw_prio: got %b want 01", gnt);
    end
    to_drv(); process = 2'b01;
    to_drv(); process = '0; hash_done = 1'b1; digest_in = DAbc;
    to_drv(); hash_done = 1'b0; to_neg();
    n_checks++;
    if (done !== 2'b01 || digest !== DAbc) begin
      n_fail++;
      $display("FAIL rstw_done: got done=%b digest=%h want 01 %h", done, digest, DAbc);
    end
    req = '0;
    wipe_cycle();
    to_drv(); to_neg();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_abc();
    test_mux();
    test_abort();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha2_arb.md
Name: sha2_arb

Overview:
Round-robin arbiter and sequencer that shares one sha2 engine among NumReq message producers (for example, HMAC register front-end and key manager).
- Grants the engine to one requester for a complete message.
- Drives the engine's control pulses and message length, and muxes the granted requester's word stream onto the engine FIFO port.
- Captures the final digest and returns it with a per-requester done pulse.
- Sits between the requester FIFOs and the sha2 instance.

Parameters:
NumReq, 2, number of requesters (2..8)
MsgLenW, 64, message length width in bits

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumReq  requester holds high for the whole message
req_len_i  in  NumReq*MsgLenW  message length in bits, slice per requester, sampled at grant
req_process_i  in  NumReq  one-cycle pulse: all words pushed
req_valid_i  in  NumReq  word valid
req_data_i  in  NumReq*36  {mask[3:0], data[31:0]} per requester
req_ready_o  out  NumReq  word accepted (valid&ready)
gnt_o  out  NumReq  one-hot grant
done_o  out  NumReq  one-cycle completion pulse to the owner
digest_o  out  256  last completed digest
sha_en_o  out  1  engine enable
hash_start_o  out  1  engine start pulse
hash_process_o  out  1  engine process pulse
message_length_o  out  MsgLenW  length forwarded to engine
fifo_rvalid_o  out  1  muxed valid
fifo_rdata_o  out  36  muxed data
fifo_rready_i  in  1  engine pops word
hash_done_i  in  1  engine completion pulse
digest_i  in  256  engine digest

Behaviour:
- Reset values: all outputs 0; FSM in Idle; round-robin pointer = NumReq-1, so requester 0 has first priority.
- FSM states: Idle, Start, Stream, Wait, Done, Abort.
- Idle:
  - If any req_i is set, pick the first set bit searching from ptr+1 cyclically.
  - Register gnt_o and message_length_o, set ptr to the winner, go to Start. Grant is visible the cycle after req_i.
- Start:
  - sha_en_o=1 and hash_start_o=1 for exactly one cycle, then go to Stream.
  - sha_en_o stays 1 in Stream, Wait and Done.
- Stream:
  - fifo_rvalid_o = req_valid_i[g]; fifo_rdata_o = req_data_i[g]; req_ready_o[g] = fifo_rready_i. These paths are combinational, with zero added latency.
  - Non-granted ready is 0. Outside Stream and Wait, fifo_rvalid_o=0 and all ready=0.
  - On req_process_i[g]: assert hash_process_o in the same cycle, go to Wait.
  - req_process_i from non-granted requesters is ignored.
- Wait:
  - The data mux stays active, because padding may still pop words.
  - On hash_done_i: register digest_i into digest_o, go to Done.
- Done:
  - done_o[g]=1 for one cycle, clear gnt_o, go to Idle.
  - digest_o holds until the next completion.
- Abort:
  - In Start, Stream or Wait, if req_i[g] deasserts, go to Abort.
  - Abort: sha_en_o=0 for one cycle (the engine clears its state), no done_o, digest_o unchanged, clear gnt_o, then go to Idle.
  - Abort takes priority over a simultaneous process or hash_done_i.
- hash_done_i outside Wait is ignored.
- Back-to-back operation: a new grant is made no earlier than the cycle after Done. The minimum gap between messages is 1 Idle cycle.
- Fairness: after a requester completes or aborts, every other pending requester is served before it is served again.
- The length is latched at grant. Changes to req_len_i during the message are ignored.

Optional Feature:
SHA2_ARB_WIPE_EN
- Defined:
  - Adds ports wipe_secret_o (1 bit) and wipe_v_o (32 bits).
  - Adds a Wipe state between Done/Abort and Idle. Wipe asserts wipe_secret_o for one cycle with wipe_v_o taken from a free-running 32-bit Galois LFSR (taps 0x80200003, seed 0xACE1_2468, never zero).
  - A grant is delayed by that one cycle.
  - digest_o is captured before the wipe.
- Undefined: no wipe ports; Done/Abort go straight to Idle.

Decomposition:
- Package sha2_arb_pkg:
  - FSM state enum.
  - Data width constant 36.
  - LFSR seed and taps.
- Sub-module rr_arb_fixed: cyclic first-set-bit search from pointer, fully combinational, parameterised by NumReq.

Test Plan:
1. Single requester 0 sends "abc" (data 0x61626300, mask 4'b1110, len 24), then process. Required: hash_start one cycle after grant, done_o[0] pulse, digest_o = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
2. req_i=2'b11 asserted repeatedly in the same cycle. Required grant order 0,1,0,1, each followed by done_o to the matching requester.
3. Requester 1 streams while requester 0 drives valid=1. Required: req_ready_o[0] stays 0 and fifo_rdata_o equals requester 1's data.
4. Requester 0 drops req_i mid-Stream. Required: one cycle of sha_en_o=0, no done_o, digest_o unchanged, and requester 1 granted next.
5. Reset asserted in Wait. Required: all outputs 0 immediately; after release, requester 0 has priority.
6. With SHA2_ARB_WIPE_EN: wipe_secret_o pulses exactly once after each done/abort with a nonzero wipe_v_o, and the next gnt_o is delayed by one cycle.
